road_frame_drawer: RTL and testbench
====================================

Name: road_frame_drawer

Overview:
- Pixel-walking draw engine between the scroll-offset register and the vga_adapter.
- On each scroll tick it repaints the road strip of the 160x120 framebuffer, one pixel per clock, from the latched scroll offset.
- Outputs (x, y, colour, plot) connect directly to the vga_adapter drawing ports; y is already wrapped, so no downstream modulo is needed.

Parameters:
- XSCREEN, 160, screen width in pixels
- YSCREEN, 120, screen height in pixels; must be a multiple of DASH_PERIOD
- ROAD_X0, 40, leftmost road column (inclusive), also the left edge line
- ROAD_X1, 119, rightmost road column (inclusive), also the right edge line
- LANE_X, 79, first column of the 2-pixel-wide centre lane marker (columns LANE_X, LANE_X+1)
- DASH_PERIOD, 8, lane dash repeat length in rows; power of two
- DASH_LEN, 4, painted rows per dash period; 0 < DASH_LEN < DASH_PERIOD
- COLOUR_W, 3, colour width (1 bit per channel)
- ROAD_COLOUR, 3'b000, asphalt colour
- EDGE_COLOUR, 3'b111, edge line colour
- LANE_COLOUR, 3'b110, lane dash colour (yellow)

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset (driven from KEY[0])
- start  in  1  one-cycle frame request (scroll tick)
- scroll_offset  in  7  current vertical scroll, 0..127
- x  out  8  pixel column
- y  out  7  pixel row
- colour  out  COLOUR_W  pixel colour
- plot  out  1  write strobe for the current x, y, colour
- busy  out  1  high while a frame is being drawn
- done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset (async, resetn=0): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; counters cleared.
- FSM states are IDLE, DRAW, FINISH.
- IDLE:
  - start=1 latches off_q: off_q = scroll_offset if scroll_offset < YSCREEN, else scroll_offset - YSCREEN (inputs 120..127 map to 0..7).
  - Clear the column counter to ROAD_X0 and the row counter to 0; set busy=1; go to DRAW.
  - start=0 keeps IDLE with plot=0.
- DRAW, one pixel per cycle, registered outputs:
  - Each cycle, plot=1 with x and y equal to the counter values of that cycle, and colour computed from them.
  - The first pixel, (ROAD_X0, 0), appears with plot=1 on the cycle after start is sampled, so latency is 1 cycle.
  - Scan order is row-major: x increments ROAD_X0 to ROAD_X1, then x returns to ROAD_X0 and y increments.
  - After pixel (ROAD_X1, YSCREEN-1), go to FINISH.
  - Frame length is (ROAD_X1-ROAD_X0+1)*YSCREEN cycles, 9600 with defaults.
- Colour rule, applied in priority order:
  - wy = y + off_q, computed 8 bits wide; if wy >= YSCREEN, subtract YSCREEN (one conditional subtract, no divider).
  - If x==ROAD_X0 or x==ROAD_X1: EDGE_COLOUR.
  - Else if x is in {LANE_X, LANE_X+1} and (wy mod DASH_PERIOD) < DASH_LEN: LANE_COLOUR. The mod is taken from the low log2(DASH_PERIOD) bits of wy.
  - Otherwise ROAD_COLOUR.
- FINISH (one cycle): plot=0, done=1, busy=0; return to IDLE. A start in the FINISH cycle is ignored.
- start while busy or in FINISH is ignored; no queuing.
- scroll_offset changes during a frame have no effect; only off_q is used.
- Reset mid-frame: the frame is abandoned immediately (plot=0, busy=0); no done pulse.
- plot is never high outside DRAW.

Decomposition:
- Package car_game_pkg holds:
  - XSCREEN/YSCREEN and the road geometry constants
  - the colour constants
  - the state enum {IDLE, DRAW, FINISH}
- One combinational sub-module, road_pixel_colour:
  - inputs x, y, off_q; output colour
  - contains the wrap subtract and the priority rule
  - reused later by the car/obstacle compositor.

Test Plan:
- Reset with resetn=0 for 3 cycles, then release -> all outputs 0, state IDLE, plot stays 0 with start=0 for 100 cycles.
- start with scroll_offset=0 -> plot at (40,0) on the next cycle; exactly 9600 plot cycles; (40,y) and (119,y) are 3'b111; (79,0..3) are 3'b110; (79,4..7) are 3'b000; (60,50)=3'b000; done pulses once, one cycle after (119,119).
- scroll_offset=3 -> (79,0)=3'b110 (wy=3); (80,1)=3'b000 (wy=4); (79,5)=3'b110 (wy=8).
- scroll_offset=118 -> (79,1)=3'b000 (wy=119); (79,2)=3'b110 (wy wraps to 0). scroll_offset=125 behaves identically to 5: (79,0)=3'b000, (79,3)=3'b110.
- start pulsed at pixel 200 and in the FINISH cycle; scroll_offset changed mid-frame -> still exactly 9600 plots and one done; colours match the original offset throughout.
- resetn asserted at pixel 500 -> plot and busy drop to 0 asynchronously, no done; a new start after release draws a full 9600-pixel frame from (40,0).

Source files
------------

// File: rtl/car_game_pkg.sv
// Shared constants and types for the car game display path.
// Holds the screen size, the road geometry, the colour palette and the
// frame-drawer state encoding. The colour function and the frame drawer
// both import this package, so geometry changes happen in one place.
package car_game_pkg;

  // Screen geometry
  localparam int unsigned XSCREEN     = 160;
  localparam int unsigned YSCREEN     = 120;  // must be a multiple of DASH_PERIOD

  // Road geometry (columns are inclusive)
  localparam int unsigned ROAD_X0     = 40;   // left edge line
  localparam int unsigned ROAD_X1     = 119;  // right edge line
  localparam int unsigned LANE_X      = 79;   // lane marker covers LANE_X and LANE_X+1
  localparam int unsigned DASH_PERIOD = 8;    // power of two
  localparam int unsigned DASH_LEN    = 4;    // painted rows per period

  // Palette, one bit per channel
  localparam int unsigned COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] ROAD_COLOUR = 3'b000;
  localparam logic [COLOUR_W-1:0] EDGE_COLOUR = 3'b111;
  localparam logic [COLOUR_W-1:0] LANE_COLOUR = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/road_pixel_colour.sv
// Combinational road colour for one framebuffer pixel.
// Ports:
//   x      in  8         pixel column
//   y      in  7         pixel row (screen space)
//   off_q  in  7         scroll offset, already reduced to 0..YSCREEN-1
//   colour out COLOUR_W  asphalt, edge line or lane dash colour
// The row is shifted into road space by the scroll offset and wrapped
// with a single conditional subtract (both operands < YSCREEN, so one
// subtract is always enough).
module road_pixel_colour
  import car_game_pkg::*;
(
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [6:0]          off_q,
  output logic [COLOUR_W-1:0] colour
);

  logic [7:0] wy_raw;
  logic [7:0] wy;
  logic       lane_on;
  logic       is_edge;
  logic       is_lane_col;

  always_comb begin
    wy_raw = {1'b0, y} + {1'b0, off_q};
    wy     = (wy_raw >= 8'(YSCREEN)) ? (wy_raw - 8'(YSCREEN)) : wy_raw;

    // DASH_PERIOD is a power of two, so the mod is a mask of the low bits
    lane_on     = ((wy & 8'(DASH_PERIOD - 1)) < 8'(DASH_LEN));
    is_edge     = (x == 8'(ROAD_X0)) || (x == 8'(ROAD_X1));
    is_lane_col = (x == 8'(LANE_X)) || (x == 8'(LANE_X + 1));

    colour = ROAD_COLOUR;
    if (is_edge) begin
      colour = EDGE_COLOUR;
    end else if (is_lane_col && lane_on) begin
      colour = LANE_COLOUR;
    end
  end

endmodule

// File: rtl/road_frame_drawer.sv
// Road strip frame drawer feeding the vga_adapter drawing ports.
// On a start pulse it latches the scroll offset and walks the road strip
// (columns ROAD_X0..ROAD_X1, rows 0..YSCREEN-1) row-major, one pixel per
// clock, then pulses done.
// Ports:
//   CLOCK_50      in  1         system clock
//   resetn        in  1         asynchronous active-low reset
//   start         in  1         one-cycle frame request, ignored unless idle
//   scroll_offset in  7         vertical scroll, 0..127
//   x             out 8         pixel column
//   y             out 7         pixel row (already wrapped, screen space)
//   colour        out COLOUR_W  pixel colour
//   plot          out 1         write strobe for x, y, colour
//   busy          out 1         high while the frame is being drawn
//   done          out 1         one-cycle pulse after the last pixel
// All outputs are registered. The x/y output registers double as the scan
// counters: the next pixel position is computed combinationally and its
// colour is evaluated on that next position, so x, y and colour land in
// their registers on the same edge.
module road_frame_drawer
  import car_game_pkg::*;
(
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                start,
  input  logic [6:0]          scroll_offset,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  state_t              state_q;
  state_t              state_d;
  logic [6:0]          off_q;
  logic [6:0]          off_d;
  logic [7:0]          x_d;
  logic [6:0]          y_d;
  logic                plot_d;
  logic                busy_d;
  logic                done_d;
  logic [COLOUR_W-1:0] colour_d;
  logic [6:0]          off_wrapped;

  // Offsets 120..127 fold back to 0..7
  assign off_wrapped = (scroll_offset >= 7'(YSCREEN)) ?
                       (scroll_offset - 7'(YSCREEN)) : scroll_offset;

  road_pixel_colour u_colour (
    .x      (x_d),
    .y      (y_d),
    .off_q  (off_d),
    .colour (colour_d)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      off_q   <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      x       <= x_d;
      y       <= y_d;
      plot    <= plot_d;
      busy    <= busy_d;
      done    <= done_d;
      if (plot_d) begin
        colour <= colour_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    x_d     = x;
    y_d     = y;
    plot_d  = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          off_d   = off_wrapped;
          x_d     = 8'(ROAD_X0);
          y_d     = '0;
          plot_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = DRAW;
        end
      end

      DRAW: begin
        // x/y hold the pixel being plotted this cycle
        if ((x == 8'(ROAD_X1)) && (y == 7'(YSCREEN - 1))) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          plot_d = 1'b1;
          if (x == 8'(ROAD_X1)) begin
            x_d = 8'(ROAD_X0);
            y_d = y + 7'd1;
          end else begin
            x_d = x + 8'd1;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_road_frame_drawer.sv
// Self-checking bench for road_frame_drawer.
module tb_road_frame_drawer;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       start;
  logic [6:0] scroll_offset;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  always #5 CLOCK_50 = ~CLOCK_50;

  road_frame_drawer dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .start         (start),
    .scroll_offset (scroll_offset),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .busy          (busy),
    .done          (done)
  );

  int total = 0;
  int bad   = 0;
  int plot_cnt = 0;
  int done_cnt = 0;

  logic [17:0] sb [$];
  logic [2:0]  fb [0:159][0:119];
  logic        prev_plot = 1'b0;
  logic [7:0]  prev_x = '0;
  logic [6:0]  prev_y = '0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference colour from screen position and raw scroll offset
  function automatic logic [2:0] model(input int px, input int py, input int off);
    int o;
    int wy;
    o  = (off >= 120) ? off - 120 : off;
    wy = (py + o) % 120;
    if (px == 40 || px == 119) return 3'b111;
    if ((px == 79 || px == 80) && (wy % 8) < 4) return 3'b110;
    return 3'b000;
  endfunction

  // Output monitor: every plot must match the next expected pixel
  always @(posedge CLOCK_50) begin
    logic [17:0] e;
    #1;
    if (plot === 1'b1) begin
      plot_cnt++;
      if (sb.size() == 0) begin
        check("plot_without_request", 32'(plot), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pixel", 32'({x, y, colour}), 32'(e));
        if (x < 8'd160 && y < 7'd120) fb[x][y] = colour;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_after_last_pixel", 32'({prev_plot, prev_x, prev_y}),
            32'({1'b1, 8'd119, 7'd119}));
      check("plot_in_finish", 32'(plot), 32'd0);
    end
    prev_plot = plot;
    prev_x    = x;
    prev_y    = y;
  end

  task automatic start_frame(input logic [6:0] off);
    @(negedge CLOCK_50);
    check("idle_no_plot", 32'(plot), 32'd0);
    for (int py = 0; py < 120; py++)
      for (int px = 40; px <= 119; px++)
        sb.push_back({8'(px), 7'(py), model(px, py, int'(off))});
    scroll_offset = off;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    check("first_pixel", 32'({plot, x, y}), 32'({1'b1, 8'd40, 7'd0}));
    check("busy_in_draw", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wait_plots(input int base, input int n, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (plot_cnt - base >= n) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLOCK_50);
    end
    if (!seen) check("plot_count_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run_frame(input logic [6:0] off);
    int b;
    int d;
    b = plot_cnt;
    d = done_cnt;
    start_frame(off);
    wait_done(12000);
    check("frame_plots", 32'(plot_cnt - b), 32'd9600);
    check("frame_dones", 32'(done_cnt - d), 32'd1);
    check("busy_in_finish", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic [6:0] off;
    int         px;
    int         py;
    logic [2:0] exp;
  } spot_t;

  spot_t spots [17];

  initial begin
    int b;
    int d;
    logic [6:0] cur;
    bit have;

    spots[0]  = '{7'd0,   40,   0, 3'b111};
    spots[1]  = '{7'd0,   40,  60, 3'b111};
    spots[2]  = '{7'd0,  119, 119, 3'b111};
    spots[3]  = '{7'd0,  119,   5, 3'b111};
    spots[4]  = '{7'd0,   79,   0, 3'b110};
    spots[5]  = '{7'd0,   79,   3, 3'b110};
    spots[6]  = '{7'd0,   80,   2, 3'b110};
    spots[7]  = '{7'd0,   79,   4, 3'b000};
    spots[8]  = '{7'd0,   79,   7, 3'b000};
    spots[9]  = '{7'd0,   60,  50, 3'b000};
    spots[10] = '{7'd3,   79,   0, 3'b110};
    spots[11] = '{7'd3,   80,   1, 3'b000};
    spots[12] = '{7'd3,   79,   5, 3'b110};
    spots[13] = '{7'd118, 79,   1, 3'b000};
    spots[14] = '{7'd118, 79,   2, 3'b110};
    spots[15] = '{7'd125, 79,   0, 3'b000};
    spots[16] = '{7'd125, 79,   3, 3'b110};

    // Reset and quiet idle
    resetn = 1'b0;
    start = 1'b0;
    scroll_offset = '0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", 32'({x, y, colour, plot, busy, done}), 32'd0);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("post_reset_outputs", 32'({x, y, colour, plot, busy, done}), 32'd0);
    b = plot_cnt;
    repeat (100) @(negedge CLOCK_50);
    check("idle_plot_count", 32'(plot_cnt - b), 32'd0);

    // Spot-check table, one frame per distinct offset
    have = 1'b0;
    cur = '0;
    for (int i = 0; i < 17; i++) begin
      if (!have || spots[i].off != cur) begin
        run_frame(spots[i].off);
        cur = spots[i].off;
        have = 1'b1;
      end
      check($sformatf("spot_%0d", i), 32'(fb[spots[i].px][spots[i].py]),
            32'(spots[i].exp));
    end

    // Start while busy, new scroll mid-frame, start during FINISH
    b = plot_cnt;
    d = done_cnt;
    start_frame(7'd7);
    wait_plots(b, 200, 400);
    start = 1'b1;
    scroll_offset = 7'd50;
    @(negedge CLOCK_50);
    start = 1'b0;
    scroll_offset = 7'd99;
    wait_done(12000);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    check("finish_start_ignored", 32'({plot, busy}), 32'd0);
    repeat (20) @(negedge CLOCK_50);
    check("busy_start_plots", 32'(plot_cnt - b), 32'd9600);
    check("busy_start_dones", 32'(done_cnt - d), 32'd1);
    check("busy_start_drained", 32'(sb.size()), 32'd0);

    // Reset mid-frame
    b = plot_cnt;
    d = done_cnt;
    start_frame(7'd0);
    wait_plots(b, 500, 800);
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", 32'({plot, busy, done}), 32'd0);
    sb.delete();
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    b = plot_cnt;
    repeat (10) @(negedge CLOCK_50);
    check("reset_no_done", 32'(done_cnt - d), 32'd0);
    check("reset_no_plots", 32'(plot_cnt - b), 32'd0);
    run_frame(7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
